// File: rtl/encoder_pkg.sv
// Shared types for the 16-4 encoder/decoder path.
package encoder_pkg;

    localparam int CODE_W = 4;
    localparam int VEC_W  = 16;

    typedef logic [VEC_W-1:0]  vec_t;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic {ACCUM, HOLD} dec_state_t;

endpackage

// File: rtl/decoder_416.sv
// Enable-gated 4-to-16 one-hot decoder; all zeros when en is low.
module decoder_416
    import encoder_pkg::*;
(
    input  logic  en,
    input  code_t code,
    output vec_t  vec
);

    // One output bit per code value, gated by the enable.
    generate
        for (genvar gi = 0; gi < VEC_W; gi++) begin : g_bit
            assign vec[gi] = en && (code == CODE_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_416_acc.sv
// Frame accumulator: ORs one-hot decoded codes into a request vector and
// presents it with population count, duplicate and forced-close flags.
module decoder_416_acc #(
    parameter  int CODE_W    = 4,
    parameter  int MAX_BEATS = 16,
    localparam int VEC_W     = 2 ** CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_gs,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VEC_W-1:0]  out_vec,
    output logic [CODE_W:0]   out_count,
    output logic              out_dup,
    output logic              out_err
);
    import encoder_pkg::*;

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    // Beat counter value seen while the limit beat itself is being accepted.
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    dec_state_t        state_reg, state_next;
    logic [VEC_W-1:0]  acc_reg, acc_next;
    logic [CODE_W:0]   count_reg, count_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic              dup_reg, dup_next;
    logic              err_reg, err_next;
    logic [VEC_W-1:0]  hit_vec;

    decoder_416 u_decoder (
        .en   (in_gs),
        .code (in_code),
        .vec  (hit_vec)
    );

    // State and accumulator registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            count_reg <= '0;
            beat_reg  <= '0;
            dup_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            beat_reg  <= beat_next;
            dup_reg   <= dup_next;
            err_reg   <= err_next;
        end
    end

    // Next-state, accumulate and handshake logic.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        beat_next  = beat_reg;
        dup_next   = dup_reg;
        err_next   = err_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        unique case (state_reg)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_next = beat_reg + 1'b1;
                    if ((hit_vec & acc_reg) != '0) begin
                        dup_next = 1'b1;
                    end else if (hit_vec != '0) begin
                        acc_next   = acc_reg | hit_vec;
                        count_next = count_reg + 1'b1;
                    end
                    // in_last takes priority over the beat limit.
                    if (in_last) begin
                        state_next = HOLD;
                    end else if (beat_reg == LAST_BEAT) begin
                        state_next = HOLD;
                        err_next   = 1'b1;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                    count_next = '0;
                    beat_next  = '0;
                    dup_next   = 1'b0;
                    err_next   = 1'b0;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    assign out_vec   = acc_reg;
    assign out_count = count_reg;
    assign out_dup   = dup_reg;
    assign out_err   = err_reg;

endmodule

// File: tb/tb_decoder_416_acc.sv
// Directed self-checking bench for decoder_416_acc (MAX_BEATS = 4).
module tb_decoder_416_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        in_gs;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_vec;
    logic [4:0]  out_count;
    logic        out_dup;
    logic        out_err;

    int checks = 0;
    int fails  = 0;

    decoder_416_acc #(.CODE_W(4), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_gs     (in_gs),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_count (out_count),
        .out_dup   (out_dup),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Presents one beat for exactly one clock edge, then idles the input.
    task automatic send_beat(input logic [3:0] code, input logic gs, input logic last);
        in_valid = 1'b1;
        in_code  = code;
        in_gs    = gs;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_code = '0; in_gs = 1'b0;
        in_last = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== 16'h0 ||
            out_count !== 5'd0 || out_dup !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset: valid=%b ready=%b vec=%h cnt=%0d dup=%b err=%b, required 0 1 0000 0 0 0",
                     out_valid, in_ready, out_vec, out_count, out_dup, out_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        send_beat(4'd2, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_mid_valid: out_valid=%b, required 0", out_valid);
        end
        send_beat(4'd10, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold: valid=%b ready=%b, required 1 0", out_valid, in_ready);
        end
        checks++;
        if (out_vec !== 16'h0404 || out_count !== 5'd2 || out_dup !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: vec=%h cnt=%0d dup=%b err=%b, required 0404 2 0 0",
                     out_vec, out_count, out_dup, out_err);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        $display("test_basic: vec=0404 frame done");
    endtask

    task automatic test_dup_empty();
        send_beat(4'd5, 1'b1, 1'b0);
        send_beat(4'd5, 1'b1, 1'b0);
        send_beat(4'd3, 1'b0, 1'b0);
        send_beat(4'd15, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 16'h8020 || out_count !== 5'd2 ||
            out_dup !== 1'b1 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL dup_empty: valid=%b vec=%h cnt=%0d dup=%b err=%b, required 1 8020 2 1 0",
                     out_valid, out_vec, out_count, out_dup, out_err);
        end
        @(posedge clk); #1;
        $display("test_dup_empty: frame done");
    endtask

    task automatic test_forced_close();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL forced_early_close: beat %0d out_valid=%b, required 0", i, out_valid);
            end
            send_beat(4'(i), 1'b1, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vec !== 16'h000F ||
            out_count !== 5'd4 || out_err !== 1'b1 || out_dup !== 1'b0) begin
            fails++;
            $display("FAIL forced_close: valid=%b ready=%b vec=%h cnt=%0d err=%b dup=%b, required 1 0 000f 4 1 0",
                     out_valid, in_ready, out_vec, out_count, out_err, out_dup);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL forced_clear: valid=%b err=%b, required 0 0", out_valid, out_err);
        end
        $display("test_forced_close: frame done");
    endtask

    task automatic test_last_on_limit();
        for (int i = 0; i < 4; i++)
            send_beat(4'(i), 1'b1, (i == 3));
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 16'h000F || out_count !== 5'd4 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL last_on_limit: valid=%b vec=%h cnt=%0d err=%b, required 1 000f 4 0",
                     out_valid, out_vec, out_count, out_err);
        end
        @(posedge clk); #1;
        $display("test_last_on_limit: frame done");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(4'd4, 1'b1, 1'b1);
        in_valid = 1'b1; in_code = 4'd1; in_gs = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vec !== 16'h0010 ||
                out_count !== 5'd1 || out_dup !== 1'b0 || out_err !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold: cycle %0d valid=%b ready=%b vec=%h cnt=%0d dup=%b err=%b, required 1 0 0010 1 0 0",
                         i, out_valid, in_ready, out_vec, out_count, out_dup, out_err);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        send_beat(4'd7, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 16'h0080 || out_count !== 5'd1 ||
            out_dup !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_next: valid=%b vec=%h cnt=%0d dup=%b err=%b, required 1 0080 1 0 0",
                     out_valid, out_vec, out_count, out_dup, out_err);
        end
        @(posedge clk); #1;
        $display("test_backpressure: frames done");
    endtask

    task automatic test_reset_mid_frame();
        send_beat(4'd3, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== 16'h0 || out_count !== 5'd0) begin
            fails++;
            $display("FAIL reset_mid_frame: valid=%b ready=%b vec=%h cnt=%0d, required 0 1 0000 0",
                     out_valid, in_ready, out_vec, out_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_beat(4'd9, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 16'h0200 || out_count !== 5'd1 ||
            out_dup !== 1'b0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_next_frame: valid=%b vec=%h cnt=%0d dup=%b err=%b, required 1 0200 1 0 0",
                     out_valid, out_vec, out_count, out_dup, out_err);
        end
        @(posedge clk); #1;
        // Reset while a result is being held must also drop out_valid at once.
        out_ready = 1'b0;
        send_beat(4'd6, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== 16'h0) begin
            fails++;
            $display("FAIL reset_in_hold: valid=%b ready=%b vec=%h, required 0 1 0000",
                     out_valid, in_ready, out_vec);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dup_empty();
        test_forced_close();
        test_last_on_limit();
        test_backpressure();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/decoder_416_acc.md
Name: decoder_416_acc

Overview:
- Receive side of the 16-4 priority-encoder path: takes a stream of 4-bit codes, each with a group-select flag, over a valid/ready handshake.
- Decodes each code to one-hot and ORs the results into a 16-bit request vector.
- A frame closes on in_last or on a beat-count limit; the block then presents the reconstructed vector with population count and error/duplicate flags.
- Sits between the encoder-side link and the 16-way request consumer.

Parameters:
- CODE_W, 4, code width; VEC_W = 2**CODE_W (16).
- MAX_BEATS, 16, maximum beats per frame before forced close; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_code  input  CODE_W  encoded index (encoder L output).
- in_gs  input  1  group select: 1 = in_code is valid; 0 = empty beat, contributes no bit.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_vec  output  VEC_W  accumulated one-hot OR.
- out_count  output  CODE_W+1  number of distinct bits set, 0..16.
- out_dup  output  1  at least one gs beat hit a bit that was already set.
- out_err  output  1  frame was force-closed at MAX_BEATS without in_last.

Behaviour:
- Reset (async assert, sync release) gives: state ACCUM; accumulator, count, beat counter and flags all 0; out_valid=0; in_ready=1; out_vec=0; out_count=0; out_dup=0; out_err=0.
- FSM has two states, ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid & in_ready; beat counter increments.
  - If in_gs=1 and bit in_code is clear: set it, count+1.
  - If in_gs=1 and the bit is already set: vector and count unchanged, dup becomes 1 (sticky for the frame).
  - If in_gs=0: vector unchanged; the beat still counts toward MAX_BEATS.
  - Accepted beat with in_last=1 -> HOLD.
  - Accepted beat that is beat number MAX_BEATS with in_last=0 -> HOLD with err=1.
  - in_last and the limit reached on the same beat -> HOLD with err=0 (last wins).
- HOLD:
  - in_ready=0, out_valid=1.
  - out_vec, out_count, out_dup and out_err are stable until the handshake.
  - out_valid & out_ready -> ACCUM next cycle, with accumulator, count, beat counter and flags cleared.
- Latency: out_valid rises the cycle after the closing beat is accepted, and the outputs include that beat's contribution.
- Throughput: at most one frame per (beats + 1) cycles. The block never accepts an input in the same cycle as an output handshake.
- out_vec, out_count, out_dup and out_err are registered and driven only from the accumulator. While out_valid=0 they show the in-progress value (don't-care for the consumer).
- Counter widths: count saturates naturally at 16 because a duplicate never increments it. Beat counter is $clog2(MAX_BEATS+1) bits and is compared for equality only.
- in_valid=0 in ACCUM: state holds. Changes on in_code, in_gs or in_last while in_valid=0 are ignored.
- Reset asserted in HOLD or mid-frame: the partial frame is discarded and out_valid drops immediately (async).
- A frame made only of gs=0 beats closes with out_vec=0 and out_count=0; it is legal.

Decomposition:
- Package encoder_pkg holds:
  - localparam CODE_W=4 and VEC_W=16;
  - typedef logic [VEC_W-1:0] vec_t;
  - typedef logic [CODE_W-1:0] code_t;
  - typedef enum logic {ACCUM, HOLD} dec_state_t.
- One sub-module, decoder_416: combinational, enable-gated one-hot decode with en = in_gs and output vec_t; all zero when en=0.
- FSM, accumulator, counters and handshake stay in the top level.

Test Plan:
- Basic frame: beats (code 2, gs 1), (code 10, gs 1, last) with out_ready=1 -> out_vec=16'h0404, out_count=2, dup=0, err=0; out_valid high for 1 cycle, 1 cycle after the last beat.
- Duplicate and empty beats: codes 5, 5, (gs 0), 15 last -> out_vec=16'h8020, out_count=2, out_dup=1.
- Forced close with MAX_BEATS=4: 4 beats codes 0,1,2,3, no last -> out_vec=16'h000F, out_err=1, in_ready=0 during HOLD.
- Last on the limit beat with MAX_BEATS=4: codes 0,1,2,3 with last on beat 4 -> out_vec=16'h000F, out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid beats not accepted. Then raise out_ready; the next frame (code 7 last) -> 16'h0080, count=1, with no carry-over.
- Reset mid-frame: accept code 3, assert rst -> out_valid=0, in_ready=1 immediately. After release, frame (code 9 last) -> out_vec=16'h0200, out_count=1.
